// File: rtl/mips_imem_loader.sv
// Boot-time instruction loader: streams words into imem from address 0 and holds the CPU in reset until release.
// Optional build macro: MIPS_IMEM_LOADER_CHECKSUM_EN adds a trailing checksum word that gates release.
module mips_imem_loader #(
  parameter int INSTR_WIDTH   = 16,
  parameter int MEM_SIZE      = 256,
  parameter int IMEM_AW       = $clog2(MEM_SIZE),
  parameter int RELEASE_DELAY = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load_start,
  input  logic [IMEM_AW:0]       load_len,
  input  logic                   s_valid,
  input  logic [INSTR_WIDTH-1:0] s_data,
  output logic                   s_ready,
  output logic                   imem_we,
  output logic [IMEM_AW-1:0]     imem_addr,
  output logic [INSTR_WIDTH-1:0] imem_wdata,
  output logic                   cpu_rst_n,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  localparam int DLY_W = (RELEASE_DELAY < 2) ? 1 : $clog2(RELEASE_DELAY + 1);
  localparam logic [IMEM_AW:0] MAX_LEN  = (IMEM_AW + 1)'(MEM_SIZE);
  localparam logic [IMEM_AW:0] CNT_ONE  = (IMEM_AW + 1)'(1);
  localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'(RELEASE_DELAY);
  localparam logic [DLY_W-1:0] DLY_ONE  = DLY_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
`ifdef MIPS_IMEM_LOADER_CHECKSUM_EN
    S_CHECK,
`endif
    S_HOLD,
    S_RUN,
    S_ERR
  } state_t;

  state_t                 state_q, state_d;
  logic [IMEM_AW:0]       cnt_q, cnt_d;
  logic [IMEM_AW:0]       len_q, len_d;
  logic [DLY_W-1:0]       dly_q, dly_d;
  logic                   we_q, we_d;
  logic [IMEM_AW-1:0]     addr_q, addr_d;
  logic [INSTR_WIDTH-1:0] wdata_q, wdata_d;
  logic                   s_ready_q, s_ready_d;
  logic                   cpu_rst_n_q, cpu_rst_n_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;
`ifdef MIPS_IMEM_LOADER_CHECKSUM_EN
  logic [INSTR_WIDTH-1:0] sum_q, sum_d;
`endif

  logic len_ok;
  logic hs;

  assign len_ok = (load_len != '0) && (load_len <= MAX_LEN);
  assign hs     = s_valid && s_ready_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    dly_d   = dly_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
`ifdef MIPS_IMEM_LOADER_CHECKSUM_EN
    sum_d   = sum_q;
`endif
    case (state_q)
      S_IDLE, S_RUN, S_ERR: begin
        if (load_start) begin
          if (len_ok) begin
            state_d = S_LOAD;
            len_d   = load_len;
            cnt_d   = '0;
`ifdef MIPS_IMEM_LOADER_CHECKSUM_EN
            sum_d   = '0;
`endif
          end else begin
            state_d = S_ERR;
          end
        end
      end
      S_LOAD: begin
        if (hs) begin
          we_d    = 1'b1;
          addr_d  = cnt_q[IMEM_AW-1:0];
          wdata_d = s_data;
          cnt_d   = cnt_q + CNT_ONE;
`ifdef MIPS_IMEM_LOADER_CHECKSUM_EN
          sum_d   = sum_q + s_data;
`endif
          if (cnt_d == len_q) begin
`ifdef MIPS_IMEM_LOADER_CHECKSUM_EN
            state_d = S_CHECK;
`else
            state_d = S_HOLD;
`endif
            dly_d   = '0;
          end
        end
      end
`ifdef MIPS_IMEM_LOADER_CHECKSUM_EN
      S_CHECK: begin
        // Checksum word is compared only, never written to memory.
        if (hs) begin
          state_d = (s_data == sum_q) ? S_HOLD : S_ERR;
          dly_d   = '0;
        end
      end
`endif
      S_HOLD: begin
        if (dly_q == DLY_LAST) state_d = S_RUN;
        else                   dly_d   = dly_q + DLY_ONE;
      end
      default: state_d = S_IDLE;
    endcase

    // Status outputs are registered from the next state so they track state_q exactly.
`ifdef MIPS_IMEM_LOADER_CHECKSUM_EN
    s_ready_d = (state_d == S_LOAD) || (state_d == S_CHECK);
    busy_d    = (state_d == S_LOAD) || (state_d == S_CHECK) || (state_d == S_HOLD);
`else
    s_ready_d = (state_d == S_LOAD);
    busy_d    = (state_d == S_LOAD) || (state_d == S_HOLD);
`endif
    cpu_rst_n_d = (state_d == S_RUN);
    done_d      = (state_d == S_RUN);
    err_d       = (state_d == S_ERR);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      len_q       <= '0;
      dly_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      s_ready_q   <= 1'b0;
      cpu_rst_n_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
`ifdef MIPS_IMEM_LOADER_CHECKSUM_EN
      sum_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      dly_q       <= dly_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      s_ready_q   <= s_ready_d;
      cpu_rst_n_q <= cpu_rst_n_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
`ifdef MIPS_IMEM_LOADER_CHECKSUM_EN
      sum_q       <= sum_d;
`endif
    end
  end

  assign s_ready    = s_ready_q;
  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign cpu_rst_n  = cpu_rst_n_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_mips_imem_loader.sv
// Directed/randomized bench for mips_imem_loader; expected writes and release timing come from the program table.
module tb_mips_imem_loader;
  localparam int IW = 16;
  localparam int MS = 256;
  localparam int AW = 8;
  localparam int RD = 4;
`ifdef MIPS_IMEM_LOADER_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          load_start;
  logic [AW:0]   load_len;
  logic          s_valid;
  logic [IW-1:0] s_data;
  logic          s_ready, imem_we, cpu_rst_n, busy, done, err;
  logic [AW-1:0] imem_addr;
  logic [IW-1:0] imem_wdata;

  int vectors = 0;
  int miscompares = 0;
  logic [IW-1:0] prog [MS];

  mips_imem_loader #(
    .INSTR_WIDTH(IW), .MEM_SIZE(MS), .IMEM_AW(AW), .RELEASE_DELAY(RD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .load_start(load_start), .load_len(load_len),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_rst_n(cpu_rst_n), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // {s_ready, imem_we, cpu_rst_n, busy, done, err}
  function automatic logic [31:0] st();
    return {26'd0, s_ready, imem_we, cpu_rst_n, busy, done, err};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
    $display("chk %-12s obs=%0h exp=%0h", tag, obs, exp);
  endtask

  // patlen>0: use pat bits per cycle then continuous; 0: continuous; <0: random gaps
  task automatic send_words(input int len, input logic [31:0] pat, input int patlen);
    int i;
    int cyc;
    bit v;
    load_start = 1'b1;
    load_len   = len[AW:0];
    step();
    load_start = 1'b0;
    chk("start", st(), 32'b100100);
    i = 0;
    cyc = 0;
    while (i < len) begin
      if (patlen > 0 && cyc < patlen) v = pat[cyc];
      else if (patlen < 0)            v = 1'($urandom_range(0, 1));
      else                            v = 1'b1;
      s_valid = v;
      s_data  = v ? prog[i] : IW'($urandom);
      step();
      cyc++;
      if (v) begin
        chk("wr_addr", 32'(imem_addr), 32'(i));
        chk("wr_data", 32'(imem_wdata), 32'(prog[i]));
        i++;
      end
      chk("wr_we", 32'(imem_we), 32'(v));
      chk("ready", 32'(s_ready), 32'((i < len) || CK));
    end
    s_valid = 1'b0;
  endtask

`ifdef MIPS_IMEM_LOADER_CHECKSUM_EN
  task automatic send_ck(input int len, input bit bad);
    logic [IW-1:0] sum;
    sum = '0;
    for (int k = 0; k < len; k++) sum = sum + prog[k];
    s_valid = 1'b1;
    s_data  = sum + IW'(bad);
    step();
    s_valid = 1'b0;
    chk("ck_nowrite", 32'(imem_we), 32'd0);
    if (bad) chk("ck_bad", st(), 32'b000001);
    else     chk("ck_ok", st(), 32'b000100);
  endtask
`endif

  task automatic hold_release();
    for (int k = 1; k <= RD; k++) begin
      step();
      chk("hold", st(), 32'b000100);
    end
    step();
    chk("release", st(), 32'b001010);
  endtask

  task automatic do_load(input int len, input logic [31:0] pat, input int patlen);
    send_words(len, pat, patlen);
`ifdef MIPS_IMEM_LOADER_CHECKSUM_EN
    send_ck(len, 1'b0);
`endif
    hold_release();
  endtask

  task automatic rand_prog(input int len);
    for (int k = 0; k < len; k++) prog[k] = IW'($urandom);
  endtask

  initial begin
    rst_n      = 1'b0;
    load_start = 1'b0;
    load_len   = '0;
    s_valid    = 1'b1;
    s_data     = 16'hdead;
    step();
    step();
    chk("reset", st(), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'd0);
    chk("rst_wdata", 32'(imem_wdata), 32'd0);
    rst_n = 1'b1;
    step();
    step();
    chk("idle_ignore", st(), 32'd0);
    s_valid = 1'b0;

    // Basic back-to-back load
    prog[0] = 16'h1111; prog[1] = 16'h2222; prog[2] = 16'h3333;
    do_load(3, 32'd0, 0);

    // Reload from RUN with gapped stream 1,0,0,1,1,0,1
    rand_prog(4);
    do_load(4, 32'b1011001, 7);

    // Invalid lengths
    load_start = 1'b1; load_len = 9'd0;
    step();
    load_start = 1'b0;
    chk("bad_len0", st(), 32'b000001);
    load_start = 1'b1; load_len = 9'd257; s_valid = 1'b1;
    step();
    load_start = 1'b0;
    chk("bad_len257", st(), 32'b000001);
    step();
    chk("err_hold", st(), 32'b000001);
    s_valid = 1'b0;

    // Recovery from ERR with a single-word load
    rand_prog(1);
    do_load(1, 32'd0, 0);

    // Reset mid-load after 2 of 5 words
    rand_prog(5);
    load_start = 1'b1; load_len = 9'd5;
    step();
    load_start = 1'b0;
    s_valid = 1'b1; s_data = prog[0];
    step();
    s_data = prog[1];
    step();
    s_valid = 1'b0;
    rst_n = 1'b0;
    step();
    chk("midrst", st(), 32'd0);
    chk("midrst_addr", 32'(imem_addr), 32'd0);
    chk("midrst_wdata", 32'(imem_wdata), 32'd0);
    rst_n = 1'b1;
    step();
    rand_prog(2);
    do_load(2, 32'd0, -1);

    // Full-depth load with random gaps reaches the top address
    rand_prog(MS);
    do_load(MS, 32'd0, -1);

`ifdef MIPS_IMEM_LOADER_CHECKSUM_EN
    prog[0] = 16'h1111; prog[1] = 16'h2222;
    send_words(2, 32'd0, 0);
    send_ck(2, 1'b1);
    step();
    chk("ck_err_stay", st(), 32'b000001);
    do_load(2, 32'd0, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
